modpow_ctrl: RTL

MODPOW_CTRL -- requirements
Module: modpow_ctrl

---
 rtl/modpow_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/modpow_ctrl.sv
// rtl/modpow_ctrl.sv - 2^p mod q controller driving external square and divide units
module modpow_ctrl #(
   parameter int PW     = 8,
   parameter int SQ_LAT = 1
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          start,
   input  logic [PW-1:0] p,
   input  logic [14:0]   q,
   output logic          busy,
   output logic          done,
   output logic [14:0]   residue,
   output logic          is_factor,
   output logic          err,
   output logic [14:0]   sq_x,
   input  logic [29:0]   sq_y,
   output logic          div_start,
   output logic [31:0]   div_num,
   output logic [31:0]   div_den,
   input  logic [31:0]   div_rem,
   input  logic          div_finished
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SQUARE,
      S_DIV_START,
      S_DIV_WAIT,
      S_NEXT,
      S_DONE
   } state_t;

   localparam int            IW      = (PW > 1) ? $clog2(PW) : 1;
   localparam logic [IW-1:0] I_TOP   = IW'(PW - 1);
   localparam logic [2:0]    SQ_LAST = 3'(SQ_LAT - 1);

   state_t        state_q, state_d;
   logic [PW-1:0] p_q, p_d;
   logic [14:0]   q_q, q_d;
   logic [14:0]   r_q, r_d;
   logic [IW-1:0] i_q, i_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [31:0]   num_q, num_d;
   logic [14:0]   residue_q, residue_d;
   logic          is_factor_q, is_factor_d;
   logic          err_q, err_d;

   // The remainder never exceeds q, so only the low 15 bits carry information.
   logic unused_rem_bits;
   assign unused_rem_bits = ^div_rem[31:15];

   // State and datapath registers; reset drops everything back to a quiet IDLE.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= S_IDLE;
         p_q         <= '0;
         q_q         <= '0;
         r_q         <= '0;
         i_q         <= '0;
         cnt_q       <= '0;
         num_q       <= '0;
         residue_q   <= '0;
         is_factor_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         p_q         <= p_d;
         q_q         <= q_d;
         r_q         <= r_d;
         i_q         <= i_d;
         cnt_q       <= cnt_d;
         num_q       <= num_d;
         residue_q   <= residue_d;
         is_factor_q <= is_factor_d;
         err_q       <= err_d;
      end
   end

   // Square-and-multiply, MSB first: r = r^2 (times 2 when the exponent bit is set) mod q.
   always_comb begin
      state_d     = state_q;
      p_d         = p_q;
      q_d         = q_q;
      r_d         = r_q;
      i_d         = i_q;
      cnt_d       = cnt_q;
      num_d       = num_q;
      residue_d   = residue_q;
      is_factor_d = is_factor_q;
      err_d       = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               p_d     = p;
               q_d     = q;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (q_q == 15'd0) begin
               err_d       = 1'b1;
               residue_d   = 15'd0;
               is_factor_d = 1'b0;
               state_d     = S_DONE;
            end else begin
               // Anything mod 1 is 0, so seed r with 1 mod q rather than plain 1.
               r_d     = (q_q == 15'd1) ? 15'd0 : 15'd1;
               i_d     = I_TOP;
               cnt_d   = 3'd0;
               state_d = S_SQUARE;
            end
         end
         S_SQUARE: begin
            if (cnt_q == SQ_LAST) begin
               // r < 2^15 keeps the doubled square below 2^31.
               num_d   = p_q[i_q] ? {1'b0, sq_y, 1'b0} : {2'b0, sq_y};
               state_d = S_DIV_START;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_DIV_START: begin
            state_d = S_DIV_WAIT;
         end
         S_DIV_WAIT: begin
            if (div_finished) begin
               r_d     = div_rem[14:0];
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (i_q == '0) begin
               residue_d   = r_q;
               is_factor_d = (r_q == 15'd1);
               err_d       = 1'b0;
               state_d     = S_DONE;
            end else begin
               i_d     = i_q - IW'(1);
               cnt_d   = 3'd0;
               state_d = S_SQUARE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done      = (state_q == S_DONE);
   assign div_start = (state_q == S_DIV_START);
   assign sq_x      = (state_q == S_SQUARE) ? r_q : 15'd0;
   assign div_num   = num_q;
   assign div_den   = {17'b0, q_q};
   assign residue   = residue_q;
   assign is_factor = is_factor_q;
   assign err       = err_q;

endmodule
